// File: rtl/muxnx1_rr_if.sv
// muxnx1_rr_if: handshake bundle for the N:1 round-robin mux.
// Ports: a/a_valid/a_ready (N producers), mode/s (grant policy),
//        y/y_valid/y_ch/y_ready (single consumer stream).
// Modports: master = producer/consumer side, slave = the mux.
interface muxnx1_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(N);

    logic [N*WIDTH-1:0] a;
    logic [N-1:0]       a_valid;
    logic [N-1:0]       a_ready;
    logic               mode;
    logic [SW-1:0]      s;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic [SW-1:0]      y_ch;
    logic               y_ready;

    modport master (
        output a, a_valid, mode, s, y_ready,
        input  a_ready, y, y_valid, y_ch
    );

    modport slave (
        input  a, a_valid, mode, s, y_ready,
        output a_ready, y, y_valid, y_ch
    );
endinterface

// File: rtl/muxnx1_rr.sv
// muxnx1_rr: N:1 mux, fixed or round-robin grant, one-entry output register.
// Ports: clk, rst_n (async, active-low), bus (muxnx1_rr_if.slave).
module muxnx1_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    muxnx1_rr_if.slave bus
);
    localparam int SW = $clog2(N);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_y;
    logic [SW-1:0]    r_ych;
    logic [SW-1:0]    r_ptr;

    logic             w_load_en;
    logic             w_gnt;
    logic [SW-1:0]    w_g;
    logic             w_xfer;
    logic [N-1:0]     w_onehot;
    logic [WIDTH-1:0] w_data;
    logic [SW-1:0]    w_ptr_nxt;

    // Register can accept when empty or being drained this cycle.
    assign w_load_en = (r_state == S_EMPTY) | bus.y_ready;

    // Round-robin search runs from the highest offset down so that the
    // channel closest to the pointer is the last (winning) assignment.
    always_comb begin
        int j;
        w_gnt = 1'b0;
        w_g   = '0;
        j     = 0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.s == SW'(i) && bus.a_valid[i]) begin
                    w_gnt = 1'b1;
                    w_g   = SW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(r_ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (bus.a_valid[j]) begin
                    w_gnt = 1'b1;
                    w_g   = SW'(j);
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_g == SW'(i)) begin
                w_data = bus.a[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer    = w_load_en & w_gnt;
    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_g;
    assign w_ptr_nxt = (w_g == SW'(N - 1)) ? '0 : w_g + SW'(1);

    // rst_n gates a_ready so no producer sees an accept while held in reset.
    assign bus.a_ready = (rst_n && w_xfer) ? w_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_y     <= '0;
            r_ych   <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_gnt) begin
                r_state <= S_FULL;
                r_y     <= w_data;
                r_ych   <= w_g;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_state <= S_EMPTY;
            end
        end
    end

    assign bus.y       = r_y;
    assign bus.y_ch    = r_ych;
    assign bus.y_valid = (r_state == S_FULL);
endmodule

// File: tb/tb_muxnx1_rr.sv
// tb_muxnx1_rr: scoreboard bench for muxnx1_rr (N=4, WIDTH=8).
// Directed scenarios followed by randomized traffic against a reference model.
module tb_muxnx1_rr;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SW    = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               ch;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muxnx1_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

    muxnx1_rr #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t            q[$];
    word_t            stage;
    bit               stage_v = 1'b0;
    int               m_ptr   = 0;
    int               errors  = 0;
    int               checks  = 0;
    bit               log_en  = 1'b0;
    int               log_q[$];
    logic [WIDTH-1:0] last_y  = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*WIDTH-1:0] rnd();
        logic [N*WIDTH-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        return v;
    endfunction

    // Drive one cycle of stimulus and predict the grant from the rules:
    // fixed select, or first valid channel walking forward from the pointer.
    task automatic cycle(input logic [N-1:0] av, input bit md, input int sv,
                         input bit yr, input logic [N*WIDTH-1:0] data);
        bit           full;
        bit           ld;
        bit           gnt;
        int           g;
        logic [N-1:0] exp_ar;
        @(negedge clk);
        #1;
        bus.a       = data;
        bus.a_valid = av;
        bus.mode    = md;
        bus.s       = SW'(sv);
        bus.y_ready = yr;
        #1;
        full = (q.size() != 0);
        ld   = !full || yr;
        gnt  = 1'b0;
        g    = 0;
        if (!md) begin
            g = sv;
            if (sv < N) gnt = av[sv];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (!gnt && av[idx]) begin
                    gnt = 1'b1;
                    g   = idx;
                end
            end
        end
        exp_ar = (ld && gnt) ? (N'(1) << g) : '0;
        chk("a_ready", bus.a_ready, exp_ar);
        if (ld && gnt) begin
            stage.d  = data[g*WIDTH +: WIDTH];
            stage.ch = g;
            stage_v  = 1'b1;
            m_ptr    = (g + 1) % N;
        end
    endtask

    // Mid-cycle async reset with a word held in y.
    task automatic do_reset();
        @(posedge clk);
        #2;
        chk("pre_rst_y_valid", bus.y_valid, (q.size() != 0));
        bus.a_valid = '1;
        bus.y_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_y", bus.y, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_y_ch", bus.y_ch, 0);
        chk("rst_a_ready", bus.a_ready, 0);
        q.delete();
        stage_v = 1'b0;
        m_ptr   = 0;
        bus.a_valid = '0;
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares what the register should hold, retires on handshake,
    // then commits the word predicted for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1) begin
                chk("y_valid", bus.y_valid, (q.size() != 0));
                if (bus.y_valid && q.size() != 0) begin
                    chk("y", bus.y, q[0].d);
                    chk("y_ch", bus.y_ch, q[0].ch);
                    if (bus.y_ready) begin
                        last_y = q[0].d;
                        if (log_en) log_q.push_back(q[0].ch);
                        void'(q.pop_front());
                    end
                end
                if (stage_v) begin
                    q.push_back(stage);
                    stage_v = 1'b0;
                end
            end
        end
    end

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            chk(name, log_q[i], exp[i]);
        end
    endtask

    initial begin
        logic [N*WIDTH-1:0] d;
        int exp_seq[$];
        rst_n       = 1'b0;
        bus.a       = '0;
        bus.a_valid = '1;
        bus.mode    = 1'b1;
        bus.s       = '0;
        bus.y_ready = 1'b0;
        #12;
        chk("init_y", bus.y, 0);
        chk("init_y_valid", bus.y_valid, 0);
        chk("init_y_ch", bus.y_ch, 0);
        chk("init_a_ready", bus.a_ready, 0);
        bus.a_valid = '0;
        rst_n = 1'b1;

        // Fixed select of channel 2.
        d = {8'h44, 8'hA5, 8'h22, 8'h11};
        cycle(4'b1111, 1'b0, 2, 1'b1, d);
        chk("fix_a_ready", bus.a_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("fix_y", bus.y, 8'hA5);
        chk("fix_y_ch", bus.y_ch, 2);
        chk("fix_y_valid", bus.y_valid, 1);

        // Reset while FULL.
        cycle(4'b1111, 1'b1, 0, 1'b0, rnd());
        do_reset();

        // Round-robin fairness.
        log_q.delete();
        log_en = 1'b1;
        repeat (8) cycle(4'b1111, 1'b1, 0, 1'b1, rnd());
        cycle(4'b0000, 1'b1, 0, 1'b1, rnd());
        #2;
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_log("rr_all", exp_seq);
        log_q.delete();
        repeat (4) cycle(4'b1001, 1'b1, 0, 1'b1, rnd());
        cycle(4'b0000, 1'b1, 0, 1'b1, rnd());
        #2;
        log_en = 1'b0;
        exp_seq = '{0, 3, 0, 3};
        chk_log("rr_1001", exp_seq);

        // Idle: y_valid falls, y keeps its last value.
        @(posedge clk);
        #1;
        chk("idle_y_valid", bus.y_valid, 0);
        chk("idle_y_hold", bus.y, last_y);

        // Fixed select of an idle channel gives no grant.
        cycle(4'b0001, 1'b0, 2, 1'b1, rnd());
        chk("nogrant_a_ready", bus.a_ready, 0);

        // Backpressure then drain-and-load with no bubble.
        cycle(4'b1111, 1'b1, 0, 1'b1, rnd());
        repeat (3) begin
            cycle(4'b1111, 1'b1, 0, 1'b0, rnd());
            chk("stall_a_ready", bus.a_ready, 0);
        end
        cycle(4'b1111, 1'b1, 0, 1'b1, rnd());
        @(posedge clk);
        #1;
        chk("nobubble_y_valid", bus.y_valid, 1);

        // Mode switch while stalled, then load via s=3 and wrap the pointer.
        cycle(4'b1111, 1'b0, 3, 1'b0, rnd());
        cycle(4'b1111, 1'b0, 3, 1'b1, rnd());
        chk("sw_a_ready", bus.a_ready, 4'b1000);
        cycle(4'b1111, 1'b1, 0, 1'b1, rnd());
        chk("wrap_a_ready", bus.a_ready, 4'b0001);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset();
            cycle(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, N - 1), ($urandom_range(0, 3) != 0), rnd());
        end
        cycle(4'b0000, 1'b0, 0, 1'b1, rnd());
        cycle(4'b0000, 1'b0, 0, 1'b1, rnd());
        #2;
        chk("drain_y_valid", bus.y_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
